// File: rtl/mcycle_writeback.sv
// Queues completed multiply/divide results (with accumulate applied) and drains them into the
// register-file write port on cycles the main pipeline leaves free, flagging RAW hazards.
module mcycle_writeback #(
   parameter int width = 32,
   parameter int DEPTH = 2
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             PushIn,
   input  logic [width-1:0] ResultHigh,
   input  logic [width-1:0] ResultLow,
   input  logic [width-1:0] AddSrc,
   input  logic             MCycleLong,
   input  logic [3:0]       MCycleWA3,
   input  logic [3:0]       MCycleWA5,
   input  logic             WBBusy,
   input  logic [3:0]       RA1,
   input  logic [3:0]       RA2,
   input  logic [3:0]       RA3,
   output logic             WE,
   output logic [3:0]       WA,
   output logic [width-1:0] WD,
   output logic             Full,
   output logic             Empty,
   output logic             Hazard,
   output logic             Overflow
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic {LO, HI} beat_t;

   logic [3:0]         wa3_q  [DEPTH];
   logic [3:0]         wa5_q  [DEPTH];
   logic               long_q [DEPTH];
   logic [2*width-1:0] sum_q  [DEPTH];

   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count;
   beat_t            beat;
   logic [3:0]       last_wa;
   logic [width-1:0] last_wd;

   logic [2*width-1:0] new_sum;
   logic               pop, push_ok;
   logic [3:0]         beat_wa;
   logic [width-1:0]   beat_wd;

   function automatic logic src_hit(input logic [3:0] d, input logic [3:0] a1,
                                    input logic [3:0] a2, input logic [3:0] a3);
      return (d == a1) || (d == a2) || (d == a3);
   endfunction

   // Short results only accumulate into the low word; the carry is discarded.
   assign new_sum = MCycleLong ? ({ResultHigh, ResultLow} + {{width{1'b0}}, AddSrc})
                               : {{width{1'b0}}, ResultLow + AddSrc};

   assign Empty   = (count == '0);
   assign Full    = (count == CW'(DEPTH));
   assign WE      = !Empty && !WBBusy;
   assign pop     = WE && (beat == HI || !long_q[rd_ptr]);
   assign push_ok = PushIn && (!Full || pop);

   assign beat_wa = (beat == HI) ? wa5_q[rd_ptr] : wa3_q[rd_ptr];
   assign beat_wd = (beat == HI) ? sum_q[rd_ptr][2*width-1:width] : sum_q[rd_ptr][width-1:0];
   assign WA      = Empty ? last_wa : beat_wa;
   assign WD      = Empty ? last_wd : beat_wd;

   always_comb begin
      logic [PW-1:0] idx;
      logic          lo_pend;
      Hazard = 1'b0;
      idx    = '0;
      lo_pend = 1'b0;
      // Destinations arriving this cycle stall decode immediately.
      if (PushIn)
         Hazard = src_hit(MCycleWA3, RA1, RA2, RA3) ||
                  (MCycleLong && src_hit(MCycleWA5, RA1, RA2, RA3));
      for (int k = 0; k < DEPTH; k++) begin
         idx     = rd_ptr + PW'(k);
         lo_pend = !(k == 0 && beat == HI);
         if (CW'(k) < count)
            if ((lo_pend && src_hit(wa3_q[idx], RA1, RA2, RA3)) ||
                (long_q[idx] && src_hit(wa5_q[idx], RA1, RA2, RA3)))
               Hazard = 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         beat     <= LO;
         Overflow <= 1'b0;
         last_wa  <= '0;
         last_wd  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            wa3_q[i]  <= '0;
            wa5_q[i]  <= '0;
            long_q[i] <= 1'b0;
            sum_q[i]  <= '0;
         end
      end else begin
         if (push_ok) begin
            wa3_q[wr_ptr]  <= MCycleWA3;
            wa5_q[wr_ptr]  <= MCycleWA5;
            long_q[wr_ptr] <= MCycleLong;
            sum_q[wr_ptr]  <= new_sum;
            wr_ptr         <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push_ok) - CW'(pop);
         if (PushIn && !push_ok)
            Overflow <= 1'b1;
         if (WE) begin
            last_wa <= beat_wa;
            last_wd <= beat_wd;
            beat    <= (beat == LO && long_q[rd_ptr]) ? HI : LO;
         end
      end
   end
endmodule

// File: tb/tb_mcycle_writeback.sv
// Directed checks of the MCycle writeback queue: latency, long split, stalls, overflow,
// push-on-final-pop and reset mid-drain.
module tb_mcycle_writeback;
   logic        CLK = 1'b0;
   logic        Reset;
   logic        PushIn;
   logic [31:0] ResultHigh, ResultLow, AddSrc;
   logic        MCycleLong;
   logic [3:0]  MCycleWA3, MCycleWA5;
   logic        WBBusy;
   logic [3:0]  RA1, RA2, RA3;
   logic        WE;
   logic [3:0]  WA;
   logic [31:0] WD;
   logic        Full, Empty, Hazard, Overflow;

   int n_cmp = 0;
   int n_err = 0;

   mcycle_writeback #(.width(32), .DEPTH(2)) dut (
      .CLK(CLK), .Reset(Reset), .PushIn(PushIn), .ResultHigh(ResultHigh),
      .ResultLow(ResultLow), .AddSrc(AddSrc), .MCycleLong(MCycleLong),
      .MCycleWA3(MCycleWA3), .MCycleWA5(MCycleWA5), .WBBusy(WBBusy),
      .RA1(RA1), .RA2(RA2), .RA3(RA3), .WE(WE), .WA(WA), .WD(WD),
      .Full(Full), .Empty(Empty), .Hazard(Hazard), .Overflow(Overflow)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic push(input logic lng, input logic [31:0] hi, input logic [31:0] lo,
                       input logic [31:0] add, input logic [3:0] wa3, input logic [3:0] wa5);
      PushIn = 1'b1; MCycleLong = lng; ResultHigh = hi; ResultLow = lo;
      AddSrc = add; MCycleWA3 = wa3; MCycleWA5 = wa5;
   endtask

   initial begin
      Reset = 1'b1; PushIn = 1'b0; ResultHigh = '0; ResultLow = '0; AddSrc = '0;
      MCycleLong = 1'b0; MCycleWA3 = '0; MCycleWA5 = '0; WBBusy = 1'b0;
      RA1 = 4'hF; RA2 = 4'hF; RA3 = 4'hF;

      // Reset state
      @(negedge CLK);
      chk("rst_we", WE, 0);       chk("rst_wa", WA, 0);       chk("rst_wd", WD, 0);
      chk("rst_full", Full, 0);   chk("rst_empty", Empty, 1);
      chk("rst_haz", Hazard, 0);  chk("rst_ovf", Overflow, 0);
      cyc(); Reset = 1'b0;

      // 1: short 0x10 + 0x5 -> r2, same-cycle hazard
      push(1'b0, 32'h0, 32'h10, 32'h5, 4'd2, 4'd0); RA1 = 4'd2;
      @(negedge CLK);
      chk("t1_haz_push", Hazard, 1); chk("t1_we_push", WE, 0);
      cyc(); PushIn = 1'b0; RA1 = 4'hF;
      @(negedge CLK);
      chk("t1_we", WE, 1); chk("t1_wa", WA, 2); chk("t1_wd", WD, 32'h15); chk("t1_empty", Empty, 0);
      cyc();
      @(negedge CLK);
      chk("t1_drained", Empty, 1); chk("t1_we_idle", WE, 0);

      // 2: long {1,FFFFFFFF}+1 = {2,0}: r4 <- 0, r5 <- 2
      push(1'b1, 32'h1, 32'hFFFF_FFFF, 32'h1, 4'd4, 4'd5);
      cyc(); PushIn = 1'b0; RA1 = 4'd4;
      @(negedge CLK);
      chk("t2_we_lo", WE, 1); chk("t2_wa_lo", WA, 4); chk("t2_wd_lo", WD, 0);
      chk("t2_haz_lo", Hazard, 1);
      cyc();
      @(negedge CLK);
      chk("t2_we_hi", WE, 1); chk("t2_wa_hi", WA, 5); chk("t2_wd_hi", WD, 2);
      chk("t2_haz_lo_done", Hazard, 0);
      #1 RA2 = 4'd5;
      #1 chk("t2_haz_hi", Hazard, 1);
      cyc(); RA1 = 4'hF; RA2 = 4'hF;
      @(negedge CLK);
      chk("t2_empty", Empty, 1);

      // 3: short -> r7 stalled 3 cycles by WBBusy
      WBBusy = 1'b1; push(1'b0, 32'h0, 32'h3, 32'h0, 4'd7, 4'd0);
      cyc(); PushIn = 1'b0; RA1 = 4'd7;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk("t3_we_busy", WE, 0); chk("t3_haz_busy", Hazard, 1); chk("t3_wa_busy", WA, 7);
         cyc();
      end
      WBBusy = 1'b0;
      @(negedge CLK);
      chk("t3_we", WE, 1); chk("t3_wa", WA, 7); chk("t3_wd", WD, 3);
      cyc(); RA1 = 4'hF;
      @(negedge CLK);
      chk("t3_empty", Empty, 1); chk("t3_haz_clr", Hazard, 0);

      // 4: fill, third push dropped
      WBBusy = 1'b1; push(1'b0, 32'h0, 32'hA, 32'h0, 4'd1, 4'd0);
      cyc(); push(1'b0, 32'h0, 32'hB, 32'h0, 4'd3, 4'd0);
      cyc(); push(1'b0, 32'h0, 32'hC, 32'h0, 4'd6, 4'd0);
      @(negedge CLK);
      chk("t4_full", Full, 1); chk("t4_ovf_pre", Overflow, 0);
      cyc(); PushIn = 1'b0;
      @(negedge CLK);
      chk("t4_ovf", Overflow, 1); chk("t4_full2", Full, 1);
      cyc(); WBBusy = 1'b0;
      @(negedge CLK);
      chk("t4_wa_a", WA, 1); chk("t4_wd_a", WD, 32'hA); chk("t4_we_a", WE, 1);
      cyc();
      @(negedge CLK);
      chk("t4_wa_b", WA, 3); chk("t4_wd_b", WD, 32'hB); chk("t4_full_clr", Full, 0);
      cyc();
      @(negedge CLK);
      chk("t4_empty", Empty, 1); chk("t4_we_none", WE, 0); chk("t4_ovf_sticky", Overflow, 1);
      cyc(); Reset = 1'b1;
      @(negedge CLK);
      chk("t4_ovf_rst", Overflow, 0);
      cyc(); Reset = 1'b0;

      // 5: full + pop + push in the same cycle
      WBBusy = 1'b1; push(1'b0, 32'h0, 32'h1, 32'h0, 4'd1, 4'd0);
      cyc(); push(1'b0, 32'h0, 32'h2, 32'h0, 4'd2, 4'd0);
      cyc(); WBBusy = 1'b0; push(1'b0, 32'h0, 32'h3, 32'h0, 4'd3, 4'd0);
      @(negedge CLK);
      chk("t5_full_pre", Full, 1); chk("t5_we1", WE, 1); chk("t5_wa1", WA, 1);
      cyc(); PushIn = 1'b0;
      @(negedge CLK);
      chk("t5_full", Full, 1); chk("t5_ovf", Overflow, 0);
      chk("t5_wa2", WA, 2); chk("t5_wd2", WD, 2);
      cyc();
      @(negedge CLK);
      chk("t5_wa3", WA, 3); chk("t5_wd3", WD, 3); chk("t5_notfull", Full, 0);
      cyc();
      @(negedge CLK);
      chk("t5_empty", Empty, 1);

      // 6: reset while high beat pending
      push(1'b1, 32'h77, 32'h66, 32'h0, 4'd8, 4'd9);
      cyc(); PushIn = 1'b0; RA1 = 4'd9;
      @(negedge CLK);
      chk("t6_wa_lo", WA, 8); chk("t6_wd_lo", WD, 32'h66);
      cyc();
      @(negedge CLK);
      chk("t6_wa_hi", WA, 9); chk("t6_haz_hi", Hazard, 1);
      #1 Reset = 1'b1;
      #1;
      chk("t6_we_rst", WE, 0); chk("t6_empty_rst", Empty, 1); chk("t6_haz_rst", Hazard, 0);
      cyc(); Reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         chk("t6_no_hi", WE, 0); chk("t6_empty", Empty, 1);
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
